// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 load/store codes, FSM states,
// access-size decode and the MEM/WB pipeline register layout.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Unknown funct3 codes fall back to a full word access.
    function automatic size_e f3_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    typedef struct packed {
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } memwb_t;

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Combinational byte-lane logic: store enables/replication, alignment check,
// and load-data extraction with sign or zero extension.
module mem_access_stage_load_store_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_offset_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;
    logic        ld_signed;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = st_data_i;
        misalign_o = 1'b0;
        case (f3_size(st_funct3_i))
            SZ_B: begin
                be_o    = 4'b0001 << st_offset_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                be_o       = 4'b0011 << st_offset_i;
                wdata_o    = {2{st_data_i[15:0]}};
                misalign_o = st_offset_i[0];
            end
            default: misalign_o = |st_offset_i;
        endcase
    end

    assign shifted   = rdata_i >> {ld_offset_i, 3'b000};
    assign ld_signed = (ld_funct3_i == F3_B) || (ld_funct3_i == F3_H);

    always_comb begin
        ld_data_o = shifted;
        case (f3_size(ld_funct3_i))
            SZ_B:    ld_data_o = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data_o = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory access at a time over a valid/ready
// bus, stalls EX while it is outstanding, and holds the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Ctl_MemtoReg_in,
    input  logic        Ctl_RegWrite_in,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic        Ctl_Branch_in,
    input  logic [4:0]  Rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        Zero_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] PCimm_in,
    input  logic [31:0] ReadData2_in,
    output logic        dmem_valid,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        PCSrc_out,
    output logic [31:0] PCimm_out,
    output logic        Ctl_MemtoReg_out,
    output logic        Ctl_RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] ALUresult_out,
    output logic [31:0] ReadData_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             we_q;
    logic [2:0]       funct3_q;
    memwb_t           memwb_q;
    logic             misalign_q;
    logic             bus_err_q;

    logic             mem_op;
    logic             misalign;
    logic             start;
    logic             done;
    logic             timeout;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      ld_data;

    mem_access_stage_load_store_align u_align (
        .st_funct3_i (funct3_in),
        .st_offset_i (ALUresult_in[1:0]),
        .st_data_i   (ReadData2_in),
        .be_o        (be),
        .wdata_o     (wdata),
        .misalign_o  (misalign),
        .ld_funct3_i (funct3_q),
        .ld_offset_i (addr_q[1:0]),
        .rdata_i     (dmem_rdata),
        .ld_data_o   (ld_data)
    );

    assign mem_op  = Ctl_MemRead_in | Ctl_MemWrite_in;
    assign start   = (state_q == IDLE) && mem_op && !misalign;
    assign done    = (state_q == ACCESS) && dmem_ready;
    assign timeout = (state_q == ACCESS) && !dmem_ready
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // An aborted access releases EX just like a completed one.
    assign stall_out = start || ((state_q == ACCESS) && !done && !timeout);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            memwb_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (mem_op && misalign) begin
                        memwb_q    <= '0;
                        misalign_q <= 1'b1;
                    end else if (mem_op) begin
                        state_q  <= ACCESS;
                        addr_q   <= ALUresult_in;
                        we_q     <= Ctl_MemWrite_in;
                        be_q     <= be;
                        wdata_q  <= wdata;
                        funct3_q <= funct3_in;
                        memwb_q  <= '0;
                    end else begin
                        memwb_q <= '{mem_to_reg: Ctl_MemtoReg_in, reg_write: Ctl_RegWrite_in,
                                     rd: Rd_in, alu_result: ALUresult_in, read_data: 32'h0};
                    end
                end
                ACCESS: begin
                    if (done) begin
                        state_q <= IDLE;
                        memwb_q <= '{mem_to_reg: Ctl_MemtoReg_in, reg_write: Ctl_RegWrite_in,
                                     rd: Rd_in, alu_result: ALUresult_in, read_data: ld_data};
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        bus_err_q <= 1'b1;
                        memwb_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign dmem_valid = (state_q == ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

    assign PCSrc_out = Ctl_Branch_in & Zero_in;
    assign PCimm_out = PCimm_in;

    assign Ctl_MemtoReg_out = memwb_q.mem_to_reg;
    assign Ctl_RegWrite_out = memwb_q.reg_write;
    assign Rd_out           = memwb_q.rd;
    assign ALUresult_out    = memwb_q.alu_result;
    assign ReadData_out     = memwb_q.read_data;
    assign misalign_out     = misalign_q;
    assign bus_err_out      = bus_err_q;

endmodule
